// File: rtl/router_3_out_arbiter_if.sv
// ---------------------------------------------------------------------------
// router_3_out_arbiter_if
// Handshake bundle between one router_3 output arbiter and its surroundings
// (the N/W/L input FIFOs, the crossbar select and the downstream credit).
//
// Signals
//   req_N/W/L    FIFO non-empty (head flit valid)
//   tail_N/W/L   head flit of that FIFO is a tail flit
//   out_ready    downstream accepts a flit this cycle
//   sel_out[2:0] crossbar select, 3'b111 when nothing is selected
//   rd_en_N/W/L  pop strobe to the granted FIFO
//   grant[2:0]   one-hot {L,W,N} lock owner, 0 when idle
//   busy         arbiter holds a packet lock
//   timeout_err  one-cycle pulse on a forced lock release
//
// Modports
//   master : FIFO/crossbar side, drives requests and sees the arbiter outputs
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface router_3_out_arbiter_if;
  logic       req_N;
  logic       req_W;
  logic       req_L;
  logic       tail_N;
  logic       tail_W;
  logic       tail_L;
  logic       out_ready;
  logic [2:0] sel_out;
  logic       rd_en_N;
  logic       rd_en_W;
  logic       rd_en_L;
  logic [2:0] grant;
  logic       busy;
  logic       timeout_err;

  modport master (
    output req_N, req_W, req_L, tail_N, tail_W, tail_L, out_ready,
    input  sel_out, rd_en_N, rd_en_W, rd_en_L, grant, busy, timeout_err
  );

  modport slave (
    input  req_N, req_W, req_L, tail_N, tail_W, tail_L, out_ready,
    output sel_out, rd_en_N, rd_en_W, rd_en_L, grant, busy, timeout_err
  );
endinterface

// File: rtl/router_3_out_arbiter.sv
// ---------------------------------------------------------------------------
// router_3_out_arbiter
// Round-robin, packet-locked (wormhole) arbiter for one router_3 output port.
// Shares the 3-input crossbar mux among the N, W and L input FIFOs and holds
// a grant from the head flit to the tail flit of a packet.
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   router_3_out_arbiter_if.slave (requests, tails, credit in;
//         crossbar select, pops, grant, busy, timeout_err out)
//
// Parameters
//   TIMEOUT_CYC  stalled-lock cycles before a forced release
//   TMO_W        width of the stall counter
//
// Configuration
//   ROUTER3_ARB_TIMEOUT_EN  when defined, a lock whose owner withholds its
//   request for TIMEOUT_CYC consecutive (non-pop) cycles is forcibly released
//   and timeout_err pulses. When undefined the lock is held indefinitely and
//   timeout_err is tied low.
// ---------------------------------------------------------------------------
`ifndef N_PORT
`define N_PORT 3'd0
`endif
`ifndef W_PORT
`define W_PORT 3'd1
`endif
`ifndef L_PORT
`define L_PORT 3'd2
`endif

module router_3_out_arbiter #(
  parameter int TIMEOUT_CYC = 16,
  parameter int TMO_W       = 5
) (
  input logic                  clk,
  input logic                  rst,
  router_3_out_arbiter_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  // Must differ from every port code so the crossbar reports no valid output.
  localparam logic [2:0] SEL_NONE = 3'b111;

  // Port index 0=N, 1=W, 2=L; cyclic successor.
  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [2:0] port_sel(input logic [1:0] p);
    case (p)
      2'd0:    return `N_PORT;
      2'd1:    return `W_PORT;
      default: return `L_PORT;
    endcase
  endfunction

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > (1 << TMO_W) - 1) begin : g_param_check
    $error("router_3_out_arbiter: TMO_W too narrow for TIMEOUT_CYC");
  end

  state_t     r_state,  w_state_nxt;
  logic [2:0] r_grant,  w_grant_nxt;
  logic [2:0] r_sel,    w_sel_nxt;
  logic [1:0] r_rr_ptr, w_rr_ptr_nxt;

  logic [2:0] w_req;
  logic [2:0] w_tail;
  logic [2:0] w_rd_en;
  logic       w_pop;
  logic       w_tail_pop;
  logic [1:0] w_owner;
  logic       w_pick_valid;
  logic [1:0] w_pick;
  logic       w_tmo_hit;

  assign w_req  = {bus.req_L,  bus.req_W,  bus.req_N};
  assign w_tail = {bus.tail_L, bus.tail_W, bus.tail_N};

  // Only the lock owner can pop, and only when it has a flit and a credit.
  assign w_rd_en    = r_grant & w_req & {3{bus.out_ready}};
  assign w_pop      = |w_rd_en;
  assign w_tail_pop = |(w_rd_en & w_tail);
  assign w_owner    = r_grant[2] ? 2'd2 : (r_grant[1] ? 2'd1 : 2'd0);

  // First requester at or after the round-robin pointer, in order N->W->L->N.
  always_comb begin
    logic [1:0] v_p;
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would infer a latch.
    w_pick_valid = 1'b0;
    w_pick       = r_rr_ptr;
    v_p          = r_rr_ptr;
    for (int k = 0; k < 3; k++) begin
      if (!w_pick_valid && w_req[v_p]) begin
        w_pick_valid = 1'b1;
        w_pick       = v_p;
      end
      v_p = next_port(v_p);
    end
  end

`ifdef ROUTER3_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_tmo_err;
  logic             w_stalled;

  // Owner holds the lock but has no flit; credit stalls are not counted.
  assign w_stalled = (r_state == ST_LOCK) && |(r_grant & ~w_req);
  assign w_tmo_hit = w_stalled && !w_pop &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      r_tmo_err <= w_tmo_hit;
      if (r_state != ST_LOCK || w_pop || w_tmo_hit)
        r_tmo_cnt <= '0;
      else if (w_stalled)
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign bus.timeout_err = r_tmo_err;
`else
  assign w_tmo_hit       = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_sel_nxt    = r_sel;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = ST_LOCK;
          w_grant_nxt = 3'b001 << w_pick;
          w_sel_nxt   = port_sel(w_pick);
        end
      end
      ST_LOCK: begin
        // Requests arriving with the tail wait for the next IDLE cycle.
        if (w_tail_pop || w_tmo_hit) begin
          w_state_nxt  = ST_IDLE;
          w_grant_nxt  = 3'b000;
          w_sel_nxt    = SEL_NONE;
          w_rr_ptr_nxt = next_port(w_owner);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 3'b000;
        w_sel_nxt   = SEL_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= 3'b000;
      r_sel    <= SEL_NONE;
      r_rr_ptr <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_sel    <= w_sel_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  assign bus.sel_out = r_sel;
  assign bus.grant   = r_grant;
  assign bus.busy    = (r_state == ST_LOCK);
  assign bus.rd_en_N = w_rd_en[0];
  assign bus.rd_en_W = w_rd_en[1];
  assign bus.rd_en_L = w_rd_en[2];

endmodule

// File: tb/tb_router_3_out_arbiter.sv
// ---------------------------------------------------------------------------
// tb_router_3_out_arbiter
// Directed scenarios plus a randomized phase for router_3_out_arbiter. Each
// input FIFO is represented by the number of flits left in its head packet;
// a reference model of the wormhole round-robin rules predicts grant, select,
// pops, busy and timeout_err every cycle.
// ---------------------------------------------------------------------------
module tb_router_3_out_arbiter;

  localparam int TMO_CYC = 16;

  logic clk;
  logic rst;

  router_3_out_arbiter_if bus ();

  router_3_out_arbiter #(
    .TIMEOUT_CYC (TMO_CYC),
    .TMO_W       (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_errors;

  // Stimulus state: flits left in each FIFO's head packet, forced req-off.
  int pkt_left [3];
  bit hold     [3];
  int refill_mode;   // 0: none, >0: fixed packet length, -1: random length
  bit rand_hold;

  // Reference model state.
  int m_owner;       // -1 when no lock
  int m_rr;          // next port to favour
  int m_stall;       // consecutive owner-empty cycles
  bit m_terr;        // expected timeout_err this cycle

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s at t=%0t: observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".sel"},   bus.sel_out, 3'b111);
    check({tag, ".grant"}, bus.grant, 3'b000);
    check({tag, ".rd_en"}, {bus.rd_en_L, bus.rd_en_W, bus.rd_en_N}, 3'b000);
    check({tag, ".busy"},  {2'b00, bus.busy}, 3'b000);
    check({tag, ".terr"},  {2'b00, bus.timeout_err}, 3'b000);
  endtask

  // Assert reset between clock edges with every input requesting; outputs
  // must take reset values at once and hold them for ncyc edges.
  task automatic reset_pulse(input string tag, input int ncyc);
    bus.req_N = 1'b1; bus.req_W = 1'b1; bus.req_L = 1'b1;
    bus.tail_N = 1'b1; bus.tail_W = 1'b0; bus.tail_L = 1'b1;
    bus.out_ready = 1'b1;
    #1 rst = 1'b0;
    #1;
    m_owner = -1; m_rr = 0; m_stall = 0; m_terr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pkt_left[i] = 0;
      hold[i]     = 1'b0;
    end
    check_reset_values(tag);
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      check_reset_values(tag);
    end
    #2 rst = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance both.
  task automatic step(input string tag, input bit rdy);
    logic [2:0] req, tail, exp_grant, exp_sel, exp_rd;
    bit         new_terr;
    for (int i = 0; i < 3; i++) begin
      if (pkt_left[i] == 0 && refill_mode != 0 && $urandom_range(0, 2) == 0)
        pkt_left[i] = (refill_mode > 0) ? refill_mode : int'($urandom_range(1, 4));
      if (rand_hold)
        hold[i] = ($urandom_range(0, 7) == 0);
      req[i]  = (pkt_left[i] > 0) && !hold[i];
      tail[i] = (pkt_left[i] == 1) ||
                (pkt_left[i] == 0 && $urandom_range(0, 1) == 1);
    end
    bus.req_N = req[0];  bus.req_W = req[1];  bus.req_L = req[2];
    bus.tail_N = tail[0]; bus.tail_W = tail[1]; bus.tail_L = tail[2];
    bus.out_ready = rdy;
    #4;

    exp_grant = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
    exp_sel   = (m_owner >= 0) ? 3'(m_owner) : 3'b111;
    exp_rd    = (m_owner >= 0 && req[m_owner] && rdy) ? exp_grant : 3'b000;
    check({tag, ".grant"}, bus.grant, exp_grant);
    check({tag, ".sel"},   bus.sel_out, exp_sel);
    check({tag, ".rd_en"}, {bus.rd_en_L, bus.rd_en_W, bus.rd_en_N}, exp_rd);
    check({tag, ".busy"},  {2'b00, bus.busy}, {2'b00, (m_owner >= 0)});
    check({tag, ".terr"},  {2'b00, bus.timeout_err}, {2'b00, m_terr});

    new_terr = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < 3; k++) begin
        if (m_owner < 0 && req[(m_rr + k) % 3])
          m_owner = (m_rr + k) % 3;
      end
      m_stall = 0;
    end else if (exp_rd != 3'b000) begin
      m_stall = 0;
      pkt_left[m_owner]--;
      if (tail[m_owner]) begin
        m_rr    = (m_owner + 1) % 3;
        m_owner = -1;
      end
    end else if (!req[m_owner]) begin
`ifdef ROUTER3_ARB_TIMEOUT_EN
      if (m_stall == TMO_CYC - 1) begin
        new_terr = 1'b1;
        m_rr     = (m_owner + 1) % 3;
        m_owner  = -1;
        m_stall  = 0;
      end else begin
        m_stall++;
      end
`endif
    end
    m_terr = new_terr;

    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    refill_mode = 0;
    rand_hold   = 1'b0;
    rst         = 1'b0;
    bus.req_N = 1'b0; bus.req_W = 1'b0; bus.req_L = 1'b0;
    bus.tail_N = 1'b0; bus.tail_W = 1'b0; bus.tail_L = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset held for 3 cycles with all inputs requesting.
    reset_pulse("reset", 3);

    // Single 4-flit packet on W, then the idle bubble.
    pkt_left[1] = 4;
    for (int c = 0; c < 7; c++) step("w_pkt", 1'b1);

    // All three ports request continuously with 2-flit packets.
    reset_pulse("rst2", 1);
    pkt_left[0] = 2; pkt_left[1] = 2; pkt_left[2] = 2;
    refill_mode = 2;
    for (int c = 0; c < 20; c++) step("rr3", 1'b1);
    refill_mode = 0;
    for (int c = 0; c < 8; c++) step("rr3_drain", 1'b1);

    // Lock on L, credit withheld for 5 cycles mid-packet; N waits.
    reset_pulse("rst3", 1);
    pkt_left[2] = 5;
    step("l_lock", 1'b1);
    pkt_left[0] = 2;
    step("l_lock", 1'b1);
    step("l_lock", 1'b1);
    for (int c = 0; c < 5; c++) step("l_stall", 1'b0);
    for (int c = 0; c < 8; c++) step("l_resume", 1'b1);

    // Lock on N, asynchronous reset mid-packet, then restart from N.
    reset_pulse("rst4", 1);
    pkt_left[0] = 4;
    step("n_lock", 1'b1);
    step("n_lock", 1'b1);
    step("n_lock", 1'b1);
    reset_pulse("mid_rst", 1);
    pkt_left[0] = 2; pkt_left[1] = 2; pkt_left[2] = 2;
    for (int c = 0; c < 4; c++) step("after_rst", 1'b1);

    // Owner W withholds its request after the header for 20 cycles.
    reset_pulse("rst5", 1);
    pkt_left[1] = 4;
    step("w_hdr", 1'b1);
    step("w_hdr", 1'b1);
    pkt_left[2] = 2;
    hold[1] = 1'b1;
    for (int c = 0; c < 20; c++) step("w_starve", 1'b1);
    hold[1] = 1'b0;
    for (int c = 0; c < 12; c++) step("w_wake", 1'b1);

    // Randomized traffic, credits and request dropouts.
    refill_mode = -1;
    rand_hold   = 1'b1;
    for (int c = 0; c < 400; c++) step("random", 1'($urandom_range(0, 3) != 0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
